// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Optional perf counters are enabled with `define MEM_ARB_PERF_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } grant_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Alternate on a tie; a lone requester always wins.
    function automatic grant_t pick_grant(
        input logic   instr_pend,
        input logic   data_pend,
        input grant_t last
    );
        if (instr_pend && data_pend) begin
            return (last == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        end else if (data_pend) begin
            return GNT_DATA;
        end
        return GNT_INSTR;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side and memory-side signals of the shared memory port.
// slave = arbiter view, master = CPU plus memory view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              instr_read;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              data_read;
    logic              data_write;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  instr_read, instr_addr,
        input  data_read, data_write, data_addr, data_in,
        input  mem_rdata, mem_ack,
        output instr_out, instr_valid,
        output data_out, data_valid, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output instr_read, instr_addr,
        output data_read, data_write, data_addr, data_in,
        output mem_rdata, mem_ack,
        input  instr_out, instr_valid,
        input  data_out, data_valid, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_perf_cnt.sv
// Saturating grant and wait-cycle counters for the memory port arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_instr_i,
    input  logic        inc_data_i,
    input  logic        inc_wait_i,
    output logic [31:0] instr_cnt_o,
    output logic [31:0] data_cnt_o,
    output logic [31:0] wait_cnt_o
);
    logic [31:0] instr_q;
    logic [31:0] data_q;
    logic [31:0] wait_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Each counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            data_q  <= '0;
            wait_q  <= '0;
        end else begin
            if (inc_instr_i) instr_q <= sat_inc(instr_q);
            if (inc_data_i)  data_q  <= sat_inc(data_q);
            if (inc_wait_i)  wait_q  <= sat_inc(wait_q);
        end
    end

    assign instr_cnt_o = instr_q;
    assign data_cnt_o  = data_q;
    assign wait_cnt_o  = wait_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data ports,
// with fair alternation and a bus-error timeout. Perf: MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_instr_cnt,
    output logic [31:0] perf_data_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t            state_q;
    grant_t            gnt_q;
    grant_t            last_q;
    grant_t            gnt_d;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] instr_out_q;
    logic [DATA_W-1:0] data_out_q;
    logic              instr_valid_q;
    logic              data_valid_q;
    logic              bus_err_q;
    logic [TW-1:0]     tmo_q;
    logic              instr_pend;
    logic              data_pend;
    logic              any_pend;

    assign instr_pend = bus.instr_read;
    assign data_pend  = bus.data_read | bus.data_write;
    assign any_pend   = instr_pend | data_pend;
    assign gnt_d      = pick_grant(instr_pend, data_pend, last_q);

    // Grant FSM: IDLE latches a request, BUSY waits for ack or timeout,
    // RESP presents the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_INSTR;
            last_q        <= GNT_INSTR;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            instr_out_q   <= '0;
            data_out_q    <= '0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            tmo_q         <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_pend) begin
                        gnt_q     <= gnt_d;
                        last_q    <= gnt_d;
                        mem_req_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= BUSY;
                        if (gnt_d == GNT_DATA) begin
                            mem_addr_q  <= bus.data_addr;
                            mem_we_q    <= bus.data_write;
                            mem_wdata_q <= bus.data_in;
                        end else begin
                            mem_addr_q  <= bus.instr_addr;
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (gnt_q == GNT_INSTR) begin
                            instr_out_q   <= bus.mem_rdata;
                            instr_valid_q <= 1'b1;
                        end else begin
                            data_valid_q <= 1'b1;
                            if (!mem_we_q) data_out_q <= bus.mem_rdata;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= RESP;
                        if (gnt_q == GNT_INSTR) begin
                            instr_out_q   <= '0;
                            instr_valid_q <= 1'b1;
                        end else begin
                            data_valid_q <= 1'b1;
                            if (!mem_we_q) data_out_q <= '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.bus_err     = bus_err_q;

`ifdef MEM_ARB_PERF_EN
    logic inc_i;
    logic inc_d;
    logic wait_i;
    logic wait_d;

    assign inc_i  = (state_q == IDLE) && any_pend && (gnt_d == GNT_INSTR);
    assign inc_d  = (state_q == IDLE) && any_pend && (gnt_d == GNT_DATA);
    assign wait_i = instr_pend && !inc_i &&
                    !((state_q != IDLE) && (gnt_q == GNT_INSTR));
    assign wait_d = data_pend && !inc_d &&
                    !((state_q != IDLE) && (gnt_q == GNT_DATA));

    mem_arb_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .inc_instr_i (inc_i),
        .inc_data_i  (inc_d),
        .inc_wait_i  (wait_i | wait_d),
        .instr_cnt_o (perf_instr_cnt),
        .data_cnt_o  (perf_data_cnt),
        .wait_cnt_o  (perf_wait_cnt)
    );
`endif

endmodule
